// File: rtl/ppu_hazard_pkg.sv
// rtl/ppu_hazard_pkg.sv - shared types and constants for the PPU hazard/stall controller
package ppu_hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/forward_select.sv
// rtl/forward_select.sv - priority forwarding select for one EX operand
module forward_select
  import ppu_hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       uses,
  input  logic [4:0] ex_rd,
  input  logic       ex_rf_enable,
  input  logic       ex_load_instr,
  input  logic [4:0] mem_rd,
  input  logic       mem_rf_enable,
  input  logic [4:0] wb_rd,
  input  logic       wb_rf_enable,
  output logic [1:0] sel
);

  // A load in EX has no result yet; the load-use stall covers that case.
  always_comb begin
    sel = FWD_RF;
    if (uses && rs != REG_X0) begin
      if (rs == ex_rd && ex_rf_enable && !ex_load_instr) sel = FWD_EX;
      else if (rs == mem_rd && mem_rf_enable)            sel = FWD_MEM;
      else if (rs == wb_rd && wb_rf_enable)              sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - hazard detection, stall/flush/hold sequencing and forwarding for the 5-stage PPU
module hazard_stall_controller
  import ppu_hazard_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rf_enable,
  input  logic             ex_load_instr,
  input  logic [4:0]       mem_rd,
  input  logic             mem_rf_enable,
  input  logic [4:0]       wb_rd,
  input  logic             wb_rf_enable,
  input  logic             ex_branch_taken,
  input  logic             mem_ram_enable,
  input  logic             ram_ready,
  output logic             cu_mux_sel,
  output logic             pc_load_en,
  output logic             ifid_load_en,
  output logic             ifid_flush,
  output logic             pipe_hold,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout_err
);

  state_t          state;
  logic [TO_W-1:0] wait_cnt;
  logic [TO_W-1:0] wait_next;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            load_use;
  logic            mem_stall;
  logic            luse_cycle;
  logic            flush_cycle;

  forward_select u_fwd_a (
    .rs            (id_rs1),
    .uses          (id_uses_rs1),
    .ex_rd         (ex_rd),
    .ex_rf_enable  (ex_rf_enable),
    .ex_load_instr (ex_load_instr),
    .mem_rd        (mem_rd),
    .mem_rf_enable (mem_rf_enable),
    .wb_rd         (wb_rd),
    .wb_rf_enable  (wb_rf_enable),
    .sel           (fwd_a)
  );

  forward_select u_fwd_b (
    .rs            (id_rs2),
    .uses          (id_uses_rs2),
    .ex_rd         (ex_rd),
    .ex_rf_enable  (ex_rf_enable),
    .ex_load_instr (ex_load_instr),
    .mem_rd        (mem_rd),
    .mem_rf_enable (mem_rf_enable),
    .wb_rd         (wb_rd),
    .wb_rf_enable  (wb_rf_enable),
    .sel           (fwd_b)
  );

  assign load_use = ex_load_instr && ex_rf_enable && (ex_rd != REG_X0) &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));

  // Once waiting, only ram_ready releases; the frozen MEM stage keeps the access pending.
  assign mem_stall   = (state == RUN) ? (mem_ram_enable && !ram_ready) : !ram_ready;
  assign flush_cycle = !mem_stall && ex_branch_taken;
  assign luse_cycle  = (state == RUN) && !mem_stall && !ex_branch_taken && load_use;

  always_comb begin
    cu_mux_sel   = 1'b0;
    pc_load_en   = 1'b1;
    ifid_load_en = 1'b1;
    ifid_flush   = 1'b0;
    pipe_hold    = 1'b0;
    fwd_a_sel    = fwd_a;
    fwd_b_sel    = fwd_b;
    if (reset) begin
      cu_mux_sel   = 1'b1;
      pc_load_en   = 1'b0;
      ifid_load_en = 1'b0;
      ifid_flush   = 1'b1;
      fwd_a_sel    = FWD_RF;
      fwd_b_sel    = FWD_RF;
    end else if (mem_stall) begin
      pipe_hold    = 1'b1;
      pc_load_en   = 1'b0;
      ifid_load_en = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush   = 1'b1;
      cu_mux_sel   = 1'b1;
      ifid_load_en = 1'b0;
    end else if (load_use) begin
      cu_mux_sel   = 1'b1;
      pc_load_en   = 1'b0;
      ifid_load_en = 1'b0;
    end
  end

  always_comb begin
    wait_next = '0;
    if (state == RUN) begin
      if (mem_stall) wait_next = TO_W'(1);
    end else if (!ram_ready) begin
      wait_next = (wait_cnt == {TO_W{1'b1}}) ? wait_cnt : wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= RUN;
      wait_cnt        <= '0;
      stall_cycles    <= '0;
      flush_count     <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state    <= mem_stall ? MEM_WAIT : RUN;
      wait_cnt <= wait_next;
      if (mem_stall && wait_next >= TO_W'(MEM_TIMEOUT)) mem_timeout_err <= 1'b1;
      if ((mem_stall || luse_cycle) && stall_cycles != {CNT_W{1'b1}})
        stall_cycles <= stall_cycles + 1'b1;
      if (flush_cycle && flush_count != {CNT_W{1'b1}})
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - randomized and directed bench with behavioural model for hazard_stall_controller
module tb_hazard_stall_controller;

  localparam int CNT_W       = 6;
  localparam int MEM_TIMEOUT = 64;
  localparam int TO_W        = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic             id_uses_rs1, id_uses_rs2;
  logic             ex_rf_enable, ex_load_instr, mem_rf_enable, wb_rf_enable;
  logic             ex_branch_taken, mem_ram_enable, ram_ready;
  logic             cu_mux_sel, pc_load_en, ifid_load_en, ifid_flush, pipe_hold;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic             mem_timeout_err;

  int n_pass = 0;
  int n_total = 0;

  // Model: "waiting" flag, length of the current hold run, counters, sticky error.
  bit m_waiting;
  int m_hold_len;
  int m_stalls;
  int m_flushes;
  bit m_err;

  hazard_stall_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_rf_enable(ex_rf_enable), .ex_load_instr(ex_load_instr),
    .mem_rd(mem_rd), .mem_rf_enable(mem_rf_enable), .wb_rd(wb_rd), .wb_rf_enable(wb_rf_enable),
    .ex_branch_taken(ex_branch_taken), .mem_ram_enable(mem_ram_enable), .ram_ready(ram_ready),
    .cu_mux_sel(cu_mux_sel), .pc_load_en(pc_load_en), .ifid_load_en(ifid_load_en),
    .ifid_flush(ifid_flush), .pipe_hold(pipe_hold), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_timeout_err(mem_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  function automatic int exp_fwd(input int rs, input bit uses);
    if (!uses || rs == 0) return 0;
    if (rs == ex_rd && ex_rf_enable && !ex_load_instr) return 1;
    if (rs == mem_rd && mem_rf_enable) return 2;
    if (rs == wb_rd && wb_rf_enable) return 3;
    return 0;
  endfunction

  function automatic bit load_use_now();
    return ex_load_instr && ex_rf_enable && ex_rd != 0 &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic bit holding_now();
    return m_waiting ? !ram_ready : (mem_ram_enable && !ram_ready);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_hold_len = 0; m_stalls = 0; m_flushes = 0; m_err = 0;
  endtask

  task automatic compare_model();
    int e_cu, e_pc, e_ifid, e_fl, e_hold;
    if (holding_now())        begin e_cu = 0; e_pc = 0; e_ifid = 0; e_fl = 0; e_hold = 1; end
    else if (ex_branch_taken) begin e_cu = 1; e_pc = 1; e_ifid = 0; e_fl = 1; e_hold = 0; end
    else if (load_use_now())  begin e_cu = 1; e_pc = 0; e_ifid = 0; e_fl = 0; e_hold = 0; end
    else                      begin e_cu = 0; e_pc = 1; e_ifid = 1; e_fl = 0; e_hold = 0; end
    chk("cu_mux_sel", cu_mux_sel, e_cu);
    chk("pc_load_en", pc_load_en, e_pc);
    chk("ifid_load_en", ifid_load_en, e_ifid);
    chk("ifid_flush", ifid_flush, e_fl);
    chk("pipe_hold", pipe_hold, e_hold);
    chk("fwd_a_sel", fwd_a_sel, exp_fwd(id_rs1, id_uses_rs1));
    chk("fwd_b_sel", fwd_b_sel, exp_fwd(id_rs2, id_uses_rs2));
    chk("stall_cycles", stall_cycles, m_stalls);
    chk("flush_count", flush_count, m_flushes);
    chk("mem_timeout_err", mem_timeout_err, m_err);
  endtask

  // Compare mid-cycle, then advance the model on the clock edge.
  task automatic cycle();
    bit hold, br, lu, was_waiting;
    #3;
    compare_model();
    hold = holding_now(); br = ex_branch_taken; lu = load_use_now(); was_waiting = m_waiting;
    @(posedge clk);
    if (hold) begin
      m_hold_len = was_waiting ? m_hold_len + 1 : 1;
      m_waiting  = 1;
      if (m_hold_len >= MEM_TIMEOUT) m_err = 1;
      m_stalls = sat_inc(m_stalls);
    end else begin
      if (br) m_flushes = sat_inc(m_flushes);
      else if (lu && !was_waiting) m_stalls = sat_inc(m_stalls);
      m_waiting = 0;
      m_hold_len = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = 0; ex_rf_enable = 0; ex_load_instr = 0;
    mem_rd = 0; mem_rf_enable = 0; wb_rd = 0; wb_rf_enable = 0;
    ex_branch_taken = 0; mem_ram_enable = 0; ram_ready = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cu"}, cu_mux_sel, 1);
    chk({tag, "_pc"}, pc_load_en, 0);
    chk({tag, "_ifid"}, ifid_load_en, 0);
    chk({tag, "_flush"}, ifid_flush, 1);
    chk({tag, "_hold"}, pipe_hold, 0);
    chk({tag, "_stall_cnt"}, stall_cycles, 0);
    chk({tag, "_flush_cnt"}, flush_count, 0);
    chk({tag, "_err"}, mem_timeout_err, 0);
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset = 0;
    model_reset();

    // Forwarding priority
    ex_rd = 5; ex_rf_enable = 1; id_rs1 = 5; id_uses_rs1 = 1;
    #2 chk("fwd_ex", fwd_a_sel, 1);
    cycle();
    ex_rf_enable = 0; mem_rd = 5; mem_rf_enable = 1;
    #2 chk("fwd_mem", fwd_a_sel, 2);
    cycle();
    mem_rf_enable = 0; wb_rd = 5; wb_rf_enable = 1;
    #2 chk("fwd_wb", fwd_a_sel, 3);
    cycle();
    id_rs1 = 0; ex_rd = 0; ex_rf_enable = 1; mem_rd = 0; mem_rf_enable = 1; wb_rd = 0;
    #2 chk("fwd_x0", fwd_a_sel, 0);
    cycle();

    // Load-use stall, then MEM forwarding
    idle_inputs();
    ex_rd = 7; ex_rf_enable = 1; ex_load_instr = 1; id_rs2 = 7; id_uses_rs2 = 1;
    #2 chk("lu_cu", cu_mux_sel, 1); chk("lu_pc", pc_load_en, 0); chk("lu_ifid", ifid_load_en, 0);
    cycle();
    ex_rd = 0; ex_rf_enable = 0; ex_load_instr = 0; mem_rd = 7; mem_rf_enable = 1;
    #2 chk("lu_fwd_b", fwd_b_sel, 2); chk("lu_stall_cnt", stall_cycles, 1);
    cycle();

    // Branch wins over load-use
    idle_inputs();
    ex_rd = 7; ex_rf_enable = 1; ex_load_instr = 1; id_rs1 = 7; id_uses_rs1 = 1; ex_branch_taken = 1;
    #2 chk("br_flush", ifid_flush, 1); chk("br_cu", cu_mux_sel, 1); chk("br_pc", pc_load_en, 1);
    cycle();
    idle_inputs();
    #2 chk("br_flush_cnt", flush_count, 1); chk("br_stall_cnt", stall_cycles, 1);
    cycle();

    // Three-cycle hold with a branch resolved during it
    mem_ram_enable = 1; ram_ready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) ex_branch_taken = 1;
      #2 chk("hold_on", pipe_hold, 1); chk("hold_no_flush", ifid_flush, 0);
      cycle();
    end
    ram_ready = 1;
    #2 chk("release_hold", pipe_hold, 0); chk("release_flush", ifid_flush, 1);
    cycle();
    idle_inputs();
    #2 chk("hold_stall_cnt", stall_cycles, 4); chk("hold_flush_cnt", flush_count, 2);
    cycle();

    // Timeout: 70 hold cycles, stall counter saturates
    mem_ram_enable = 1; ram_ready = 0;
    for (int i = 1; i <= 70; i++) begin
      cycle();
      if (i == 63) chk("timeout_not_yet", mem_timeout_err, 0);
      if (i == 64) chk("timeout_set", mem_timeout_err, 1);
    end
    ram_ready = 1;
    cycle();
    idle_inputs();
    #2 chk("timeout_sticky", mem_timeout_err, 1); chk("stall_saturated", stall_cycles, CNT_MAX);
    cycle();

    // Asynchronous reset in the middle of a wait
    mem_ram_enable = 1; ram_ready = 0;
    cycle(); cycle();
    #3 reset = 1;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1 reset = 0;
    model_reset();
    idle_inputs();
    #2 chk("post_reset_pc", pc_load_en, 1); chk("post_reset_run", pipe_hold, 0);
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      ex_rd = 5'($urandom_range(0, 7)); mem_rd = 5'($urandom_range(0, 7)); wb_rd = 5'($urandom_range(0, 7));
      id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_rf_enable = 1'($urandom_range(0, 1)); ex_load_instr = ($urandom_range(0, 2) == 0);
      mem_rf_enable = 1'($urandom_range(0, 1)); wb_rf_enable = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 6) == 0);
      mem_ram_enable = ($urandom_range(0, 3) == 0);
      ram_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RISC-V PPU.
- Drives the selector of the ID-stage control-unit multiplexer, so a selector value of 1 inserts a bubble with all control signals zeroed.
- Drives the PC and IF/ID load enables, the IF/ID flush, the global pipeline hold for slow data-RAM accesses, and the EX operand forwarding selects.
- Keeps saturating stall and flush counters and a sticky RAM-timeout error flag.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters.
- MEM_TIMEOUT, 64, cycles in MEM_WAIT after which mem_timeout_err is set.
- TO_W, 8, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction reads that source.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_rf_enable  in  1  the EX instruction writes the register file.
- ex_load_instr  in  1  the EX instruction is a load.
- mem_rd  in  5  destination register of the instruction in MEM.
- mem_rf_enable  in  1  the MEM instruction writes the register file.
- wb_rd  in  5  destination register of the instruction in WB.
- wb_rf_enable  in  1  the WB instruction writes the register file.
- ex_branch_taken  in  1  a jump or taken branch is resolved in EX.
- mem_ram_enable  in  1  the MEM instruction accesses data RAM.
- ram_ready  in  1  data RAM completes the access this cycle.
- cu_mux_sel  out  1  1 = bubble into ID/EX.
- pc_load_en  out  1  PC register load enable.
- ifid_load_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- pipe_hold  out  1  freeze the ID/EX, EX/MEM and MEM/WB registers.
- fwd_a_sel, fwd_b_sel  out  2 each  0 = RF, 1 = EX result, 2 = MEM result, 3 = WB result.
- stall_cycles  out  CNT_W  saturating count of stall and hold cycles.
- flush_count  out  CNT_W  saturating count of flushes.
- mem_timeout_err  out  1  sticky; cleared only by reset.

Behaviour:
- Reset, while asserted:
  - state = RUN; counters, wait counter and mem_timeout_err = 0.
  - cu_mux_sel=1, pc_load_en=0, ifid_load_en=0, ifid_flush=1, pipe_hold=0, fwd selects = 0.
- Control outputs are combinational from state and inputs, so they take effect in the same cycle. Counters and the error flag are registered.
- Forwarding, per operand, highest priority first:
  - EX match: rs == ex_rd, ex_rf_enable, and not ex_load_instr -> 1.
  - Else MEM match (mem_rd, mem_rf_enable) -> 2.
  - Else WB match (wb_rd, wb_rf_enable) -> 3.
  - Else 0.
  - rs == 0 or the corresponding id_uses_rsX low -> always 0.
- Load-use hazard: ex_load_instr, ex_rf_enable, ex_rd != 0, and ex_rd matches a used rs.
- FSM states are RUN and MEM_WAIT.
- RUN, conditions checked in priority order:
  1. Hold: mem_ram_enable && !ram_ready -> pipe_hold=1, pc_load_en=0, ifid_load_en=0, cu_mux_sel=0. Next state MEM_WAIT, wait counter = 1.
  2. Flush: ex_branch_taken -> ifid_flush=1, cu_mux_sel=1, pc_load_en=1 to load the target. flush_count +1.
  3. Load-use stall: pc_load_en=0, ifid_load_en=0, cu_mux_sel=1, lasting exactly one cycle. The next cycle the load is in MEM and forwarding selects 2.
  4. Otherwise: pc_load_en=1, ifid_load_en=1, all others 0.
- MEM_WAIT:
  - Hold outputs as in RUN rule 1.
  - On ram_ready: release in that same cycle with all enables as in normal RUN; next state RUN.
  - Otherwise the wait counter increments, saturating. When it reaches MEM_TIMEOUT, mem_timeout_err is set and waiting continues.
- Simultaneous events:
  - Flush vs load-use in the same cycle: flush wins, because the ID instruction is wrong-path.
  - Branch taken during a hold: deferred. EX is frozen, so ex_branch_taken persists and the flush executes on the release cycle.
- stall_cycles increments on every load-use stall cycle and every hold cycle; it does not increment on the release cycle.
- Counters saturate at 2^CNT_W−1 with no wrap.
- Reset during MEM_WAIT returns immediately to RUN; mem_timeout_err is cleared.

Decomposition:
- Shared package ppu_hazard_pkg holds:
  - the state enum (RUN, MEM_WAIT);
  - FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3;
  - the x0 register index constant.
- One sub-module, forward_select, instantiated twice for operands A and B. Pure priority compare of rs against the EX, MEM and WB destinations.

Test Plan:
- EX writes x5 (not a load), ID reads rs1=x5 -> fwd_a_sel=1. Same x5 in MEM only -> 2. In WB only -> 3. rs1=x0 with ex_rd=0 -> 0.
- Load to x7 in EX, ID reads rs2=x7 -> one cycle with cu_mux_sel=1, pc_load_en=0, ifid_load_en=0. Next cycle fwd_b_sel=2 and stall_cycles=1.
- ex_branch_taken=1 together with a load-use hazard -> ifid_flush=1, cu_mux_sel=1, pc_load_en=1, flush_count=1, stall_cycles unchanged.
- mem_ram_enable=1 with ram_ready low for 3 cycles -> pipe_hold=1 for 3 cycles, release on the 4th, stall_cycles=3. A branch taken during the hold flushes only on the release cycle.
- ram_ready held low for 70 cycles with MEM_TIMEOUT=64 -> mem_timeout_err=1 from wait count 64, stays high after release, clears only on reset.
- Reset asserted mid-MEM_WAIT -> outputs take their reset values asynchronously. After deassertion: state RUN, pc_load_en=1 on the first idle cycle, all counters 0.
